// File: rtl/calu_pkg.sv
// calu_pkg: shared widths, iteration count, divider state encoding and a
// two's-complement negate helper.
package calu_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ITER_CNT = 16;
    localparam int unsigned CNT_W    = $clog2(ITER_CNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Two's-complement negation at the data width.
    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] x);
        return ~x + DATA_W'(1);
    endfunction

endpackage

// File: rtl/adder_subtractor_16bit.sv
// adder_subtractor_16bit: combinational add/subtract.
//   A, B : operands
//   Sub  : 1 -> Sum = A - B - Cin, 0 -> Sum = A + B + Cin
//   Cin  : carry in (borrow in when subtracting)
//   Sum  : result
//   Cout : carry out; when subtracting, 1 means no borrow
module adder_subtractor_16bit
    import calu_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              Sub,
    input  logic              Cin,
    output logic [DATA_W-1:0] Sum,
    output logic              Cout
);

    logic [DATA_W-1:0] b_eff;
    logic              cin_eff;

    // Subtraction as A + ~B + ~Cin.
    assign b_eff   = Sub ? ~B : B;
    assign cin_eff = Sub ? ~Cin : Cin;

    assign {Cout, Sum} = (DATA_W+1)'(A) + (DATA_W+1)'(b_eff) + (DATA_W+1)'(cin_eff);

endmodule

// File: rtl/seq_divider_16bit.sv
// seq_divider_16bit: 16-bit sequential restoring divider, one quotient bit
// per cycle. Latency 18 cycles from acceptance to Done (1 cycle for B=0).
// Optional macro SIGNED_DIV_EN adds truncating signed division.
//   clk, rst   : clock, asynchronous active-high reset
//   Start      : request, sampled only when idle
//   A, B       : dividend, divisor (captured on acceptance)
//   Signed     : (SIGNED_DIV_EN only) signed mode, captured on acceptance
//   Busy       : state is not IDLE
//   Done       : one-cycle result-valid pulse
//   Quotient   : registered quotient
//   Remainder  : registered remainder
//   DivByZero  : registered flag, B was zero
//   Overflow   : registered flag, signed 16'h8000 / 16'hFFFF
module seq_divider_16bit
    import calu_pkg::*;
#(
    parameter logic [DATA_W-1:0] DIVZ_QUOT = 16'hFFFF
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              Start,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
`ifdef SIGNED_DIV_EN
    input  logic              Signed,
`endif
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Quotient,
    output logic [DATA_W-1:0] Remainder,
    output logic              DivByZero,
    output logic              Overflow
);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dq_q, dq_d;      // dividend shifting out, quotient shifting in
    logic [DATA_W-1:0] rem_q, rem_d;    // partial remainder
    logic [DATA_W-1:0] div_q, div_d;    // divisor magnitude
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] quot_q, quot_d;
    logic [DATA_W-1:0] remd_q, remd_d;
    logic              dbz_q, dbz_d;

    logic [DATA_W:0]   shifted;
    logic [DATA_W-1:0] diff;
    logic              no_borrow;
    logic              take;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;

`ifdef SIGNED_DIV_EN
    logic qneg_q, qneg_d;   // negate quotient in FIX
    logic rneg_q, rneg_d;   // negate remainder in FIX
    logic ovfp_q, ovfp_d;   // 8000/FFFF overflow case pending
    logic ovf_q,  ovf_d;

    assign a_mag = (Signed && A[DATA_W-1]) ? negate(A) : A;
    assign b_mag = (Signed && B[DATA_W-1]) ? negate(B) : B;
`else
    assign a_mag = A;
    assign b_mag = B;
`endif

    // 17-bit partial remainder shifted left with the next dividend bit.
    assign shifted = {rem_q, dq_q[DATA_W-1]};

    adder_subtractor_16bit u_trial (
        .A    (shifted[DATA_W-1:0]),
        .B    (div_q),
        .Sub  (1'b1),
        .Cin  (1'b0),
        .Sum  (diff),
        .Cout (no_borrow)
    );

    // A set 17th bit means the shifted value exceeds any 16-bit divisor.
    assign take = shifted[DATA_W] | no_borrow;

    // Next-state and datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dq_d    = dq_q;
        rem_d   = rem_q;
        div_d   = div_q;
        quot_d  = quot_q;
        remd_d  = remd_q;
        dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        ovfp_d  = ovfp_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (Start) begin
                    dbz_d = 1'b0;
`ifdef SIGNED_DIV_EN
                    ovf_d  = 1'b0;
                    qneg_d = Signed & (A[DATA_W-1] ^ B[DATA_W-1]);
                    rneg_d = Signed & A[DATA_W-1];
                    ovfp_d = Signed & (A == 16'h8000) & (B == 16'hFFFF);
`endif
                    if (B == '0) begin
                        quot_d  = DIVZ_QUOT;
                        remd_d  = A;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = '0;
                        rem_d   = '0;
                        dq_d    = a_mag;
                        div_d   = b_mag;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = take ? diff : shifted[DATA_W-1:0];
                dq_d  = {dq_q[DATA_W-2:0], take};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER_CNT - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
`ifdef SIGNED_DIV_EN
                quot_d = qneg_q ? negate(dq_q) : dq_q;
                remd_d = rneg_q ? negate(rem_q) : rem_q;
                ovf_d  = ovfp_q;
`else
                quot_d = dq_q;
                remd_d = rem_q;
`endif
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dq_q    <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            remd_q  <= '0;
            dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            ovfp_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dq_q    <= dq_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
            dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            ovfp_q  <= ovfp_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Quotient  = quot_q;
    assign Remainder = remd_q;
    assign DivByZero = dbz_q;
`ifdef SIGNED_DIV_EN
    assign Overflow  = ovf_q;
`else
    assign Overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider_16bit.sv
// tb_seq_divider_16bit: directed self-checking bench for seq_divider_16bit.
// Signed scenarios are compiled in only when SIGNED_DIV_EN is defined.
module tb_seq_divider_16bit;

    logic        clk;
    logic        rst;
    logic        Start;
    logic [15:0] A;
    logic [15:0] B;
`ifdef SIGNED_DIV_EN
    logic        Signed;
`endif
    logic        Busy;
    logic        Done;
    logic [15:0] Quotient;
    logic [15:0] Remainder;
    logic        DivByZero;
    logic        Overflow;

    int n_tests;
    int n_fail;

    seq_divider_16bit #(.DIVZ_QUOT(16'hFFFF)) dut (
        .clk       (clk),
        .rst       (rst),
        .Start     (Start),
        .A         (A),
        .B         (B),
`ifdef SIGNED_DIV_EN
        .Signed    (Signed),
`endif
        .Busy      (Busy),
        .Done      (Done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivByZero (DivByZero),
        .Overflow  (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request while idle; returns just after the accepting edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        A     = a;
        B     = b;
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    // Edges after the accepting edge until Done is seen (40 = timed out).
    task automatic wait_done(output int lat);
        lat = 0;
        while (!Done && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_tests++;
        if ({Busy, Done, Quotient, Remainder, DivByZero, Overflow} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dbz=%b ovf=%b want all 0",
                     Busy, Done, Quotient, Remainder, DivByZero, Overflow);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int lat;
        start_op(16'd100, 16'd7);
        n_tests++;
        if (Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got %b want 1", Busy);
        end
        wait_done(lat);
        n_tests++;
        if (lat !== 17) begin
            n_fail++;
            $display("FAIL basic_latency: got Done at edge %0d want edge 18", lat + 1);
        end
        n_tests++;
        if (Quotient !== 16'd14 || Remainder !== 16'd2 || DivByZero !== 1'b0 || Overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got q=%0d r=%0d dbz=%b ovf=%b want q=14 r=2 dbz=0 ovf=0",
                     Quotient, Remainder, DivByZero, Overflow);
        end
        step();
        n_tests++;
        if (Done !== 1'b0 || Busy !== 1'b0 || Quotient !== 16'd14 || Remainder !== 16'd2) begin
            n_fail++;
            $display("FAIL basic_after_done: got done=%b busy=%b q=%0d r=%0d want done=0 busy=0 q=14 r=2",
                     Done, Busy, Quotient, Remainder);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        start_op(16'hFFFF, 16'h0001);
        lat = 0;
        while (!Done && lat < 40) begin
            if (lat == 4) begin
                Start = 1'b1;
                A     = 16'd3;
                B     = 16'd3;
            end
            step();
            Start = 1'b0;
            lat++;
        end
        n_tests++;
        if (lat !== 17) begin
            n_fail++;
            $display("FAIL ignore_latency: got Done at edge %0d want edge 18", lat + 1);
        end
        n_tests++;
        if (Quotient !== 16'hFFFF || Remainder !== 16'h0000) begin
            n_fail++;
            $display("FAIL ignore_result: got q=%h r=%h want q=ffff r=0000", Quotient, Remainder);
        end
        step();
        n_tests++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_no_queue: got busy=%b done=%b want 0 0", Busy, Done);
        end
    endtask

    task automatic test_divzero();
        int lat;
        start_op(16'd5, 16'd0);
        wait_done(lat);
        n_tests++;
        if (lat !== 0) begin
            n_fail++;
            $display("FAIL divzero_latency: got Done at edge %0d want edge 1", lat + 1);
        end
        n_tests++;
        if (Quotient !== 16'hFFFF || Remainder !== 16'd5 || DivByZero !== 1'b1 || Overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL divzero_result: got q=%h r=%h dbz=%b ovf=%b want q=ffff r=0005 dbz=1 ovf=0",
                     Quotient, Remainder, DivByZero, Overflow);
        end
        step();
        n_tests++;
        if (Done !== 1'b0 || DivByZero !== 1'b1) begin
            n_fail++;
            $display("FAIL divzero_hold: got done=%b dbz=%b want done=0 dbz=1", Done, DivByZero);
        end
    endtask

    // Start driven in the cycle right after DONE; flag from the prior op clears on acceptance.
    task automatic test_back_to_back();
        int lat;
        start_op(16'd1000, 16'd10);
        n_tests++;
        if (Busy !== 1'b1 || DivByZero !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b dbz=%b want busy=1 dbz=0", Busy, DivByZero);
        end
        wait_done(lat);
        step();
        start_op(16'd1001, 16'd10);
        n_tests++;
        if (Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_accept: got busy=%b want 1", Busy);
        end
        wait_done(lat);
        n_tests++;
        if (lat !== 17 || Quotient !== 16'd100 || Remainder !== 16'd1) begin
            n_fail++;
            $display("FAIL b2b_result: got edge=%0d q=%0d r=%0d want edge=18 q=100 r=1",
                     lat + 1, Quotient, Remainder);
        end
        step();
    endtask

    task automatic test_vectors();
        logic [15:0] va [6];
        logic [15:0] vb [6];
        logic [15:0] vq [6];
        logic [15:0] vr [6];
        int lat;
        va = '{16'd1000, 16'd7,   16'hFFFF, 16'hFFFF, 16'h8000, 16'd12345};
        vb = '{16'd1000, 16'd100, 16'hFFFF, 16'd2,    16'hFFFF, 16'd123};
        vq = '{16'd1,    16'd0,   16'd1,    16'h7FFF, 16'd0,    16'd100};
        vr = '{16'd0,    16'd7,   16'd0,    16'd1,    16'h8000, 16'd45};
        for (int i = 0; i < 6; i++) begin
            start_op(va[i], vb[i]);
            wait_done(lat);
            n_tests++;
            if (lat !== 17 || Quotient !== vq[i] || Remainder !== vr[i] || Overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL vector_%0d: %h/%h got edge=%0d q=%h r=%h ovf=%b want edge=18 q=%h r=%h ovf=0",
                         i, va[i], vb[i], lat + 1, Quotient, Remainder, Overflow, vq[i], vr[i]);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        start_op(16'd100, 16'd7);
        repeat (7) step();
        #3;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({Busy, Done, Quotient, Remainder, DivByZero, Overflow} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b q=%h r=%h dbz=%b ovf=%b want all 0",
                     Busy, Done, Quotient, Remainder, DivByZero, Overflow);
        end
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (Done || Busy) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: got %0d busy/done cycles want 0", seen);
        end
        // Recovery after abort.
        start_op(16'd50, 16'd6);
        wait_done(seen);
        n_tests++;
        if (seen !== 17 || Quotient !== 16'd8 || Remainder !== 16'd2) begin
            n_fail++;
            $display("FAIL reset_recover: got edge=%0d q=%0d r=%0d want edge=18 q=8 r=2",
                     seen + 1, Quotient, Remainder);
        end
        step();
    endtask

`ifdef SIGNED_DIV_EN
    task automatic test_signed();
        logic [15:0] va [5];
        logic [15:0] vb [5];
        logic [15:0] vq [5];
        logic [15:0] vr [5];
        logic        vo [5];
        int lat;
        va = '{16'hFFF9, 16'h0007, 16'hFFF9, 16'h8000, 16'h0064};
        vb = '{16'h0002, 16'hFFFE, 16'hFFFE, 16'hFFFF, 16'h0007};
        vq = '{16'hFFFD, 16'hFFFD, 16'h0003, 16'h8000, 16'h000E};
        vr = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 16'h0002};
        vo = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b0};
        Signed = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start_op(va[i], vb[i]);
            wait_done(lat);
            n_tests++;
            if (lat !== 17 || Quotient !== vq[i] || Remainder !== vr[i] || Overflow !== vo[i]) begin
                n_fail++;
                $display("FAIL signed_%0d: %h/%h got edge=%0d q=%h r=%h ovf=%b want edge=18 q=%h r=%h ovf=%b",
                         i, va[i], vb[i], lat + 1, Quotient, Remainder, Overflow, vq[i], vr[i], vo[i]);
            end
            step();
        end
        // Overflow flag clears when the next request is accepted.
        start_op(16'h0009, 16'h0003);
        n_tests++;
        if (Overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL signed_ovf_clear: got %b want 0", Overflow);
        end
        wait_done(lat);
        step();
        Signed = 1'b0;
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        Start   = 1'b0;
        A       = '0;
        B       = '0;
`ifdef SIGNED_DIV_EN
        Signed  = 1'b0;
`endif
        test_reset();
        test_basic();
        test_ignore_start();
        test_divzero();
        test_back_to_back();
        test_vectors();
        test_reset_mid();
`ifdef SIGNED_DIV_EN
        test_signed();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
